// File: rtl/operand_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// alu_cond_pkg
// Shared types and helpers for the ALU B-input operand conditioner.
//   cond_mode_t   : transform select carried on the Mode port
//   COND_MODE_W   : width of the Mode field
//   nines_nibble  : BCD nines' complement of one nibble, wrapping mod 16
// -----------------------------------------------------------------------------
package alu_cond_pkg;

    localparam int COND_MODE_W = 3;

    // Codes 6 and 7 are reserved; they pass the operand and flag ModeErr.
    typedef enum logic [COND_MODE_W-1:0] {
        PASS   = 3'd0,
        INVERT = 3'd1,
        NEGATE = 3'd2,
        NINES  = 3'd3,
        ZERO   = 3'd4,
        ONES   = 3'd5
    } cond_mode_t;

    // 9 - d, truncated to 4 bits, so non-BCD digits wrap (A -> F, F -> A).
    function automatic logic [3:0] nines_nibble(input logic [3:0] digit);
        return 4'd9 - digit;
    endfunction

endpackage

// File: rtl/operand_conditioner_transform.sv
// -----------------------------------------------------------------------------
// cond_transform
// Purely combinational operand transform feeding the conditioner registers.
//   data     in  WIDTH : operand
//   mode     in  3     : transform select (cond_mode_t)
//   result   out WIDTH : transformed operand
//   carry    out 1     : carry out of the NEGATE increment, 0 otherwise
//   zero     out 1     : result is all zeros
//   mode_err out 1     : mode is a reserved code
// WIDTH must be a multiple of 4 and at least 4.
// -----------------------------------------------------------------------------
module cond_transform
    import alu_cond_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]       data,
    input  logic [COND_MODE_W-1:0] mode,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic                   zero,
    output logic                   mode_err
);

    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             mode_err_s;

    // Select the transform; reserved codes fall through to pass with an error flag.
    always_comb begin
        result_s   = data;
        carry_s    = 1'b0;
        mode_err_s = 1'b0;
        case (mode)
            PASS:   result_s = data;
            INVERT: result_s = ~data;
            // Carry only escapes when ~data is all ones, i.e. data == 0.
            NEGATE: {carry_s, result_s} = {1'b0, ~data} + {{WIDTH{1'b0}}, 1'b1};
            NINES: begin
                for (int i = 0; i < WIDTH / 4; i++) begin
                    result_s[i*4 +: 4] = nines_nibble(data[i*4 +: 4]);
                end
            end
            ZERO:   result_s = {WIDTH{1'b0}};
            ONES:   result_s = {WIDTH{1'b1}};
            default: begin
                result_s   = data;
                mode_err_s = 1'b1;
            end
        endcase
    end

    assign result   = result_s;
    assign carry    = carry_s;
    assign zero     = (result_s == {WIDTH{1'b0}});
    assign mode_err = mode_err_s;

endmodule

// File: rtl/operand_conditioner.sv
// -----------------------------------------------------------------------------
// operand_conditioner
// Pipelined ALU B-input conditioner: transform, then a main register (M) with
// a one-entry skid register (S) behind a valid/ready handshake.
//   Clk      in  1     : rising-edge clock
//   Rst_n    in  1     : asynchronous active-low reset
//   InValid  in  1     : producer offers DataBus/Mode
//   InReady  out 1     : operand can be accepted (skid register empty)
//   DataBus  in  WIDTH : operand
//   Mode     in  3     : transform select (cond_mode_t)
//   OutValid out 1     : DataOut and flags valid
//   OutReady in  1     : consumer takes the output this cycle
//   DataOut  out WIDTH : conditioned operand
//   CarryOut out 1     : NEGATE carry
//   ZeroOut  out 1     : DataOut == 0
//   ModeErr  out 1     : reserved Mode used for this result
// -----------------------------------------------------------------------------
module operand_conditioner
    import alu_cond_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [WIDTH-1:0]       DataBus,
    input  logic [COND_MODE_W-1:0] Mode,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [WIDTH-1:0]       DataOut,
    output logic                   CarryOut,
    output logic                   ZeroOut,
    output logic                   ModeErr
);

    // Payload layout: {data, carry, zero, mode_err}.
    localparam int PW = WIDTH + 3;
    localparam logic [PW-1:0] RESET_PAYLOAD = {{WIDTH{1'b0}}, 1'b0, 1'b1, 1'b0};

    logic [WIDTH-1:0] xf_data_s;
    logic             xf_carry_s;
    logic             xf_zero_s;
    logic             xf_err_s;
    logic [PW-1:0]    new_payload_s;
    logic [PW-1:0]    m_payload_r;
    logic [PW-1:0]    s_payload_r;
    logic             m_valid_r;
    logic             s_full_r;
    logic             accept_s;
    logic             drain_s;

    cond_transform #(.WIDTH(WIDTH)) u_transform (
        .data     (DataBus),
        .mode     (Mode),
        .result   (xf_data_s),
        .carry    (xf_carry_s),
        .zero     (xf_zero_s),
        .mode_err (xf_err_s)
    );

    assign new_payload_s = {xf_data_s, xf_carry_s, xf_zero_s, xf_err_s};

    // InReady depends only on the skid flop, so OutReady never reaches it.
    assign InReady  = ~s_full_r;
    assign accept_s = InValid & ~s_full_r;
    assign drain_s  = m_valid_r & OutReady;

    // M/S occupancy and data movement; S only fills while M is held.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_valid_r   <= 1'b0;
            s_full_r    <= 1'b0;
            m_payload_r <= RESET_PAYLOAD;
            s_payload_r <= {PW{1'b0}};
        end else if (drain_s && s_full_r) begin
            // InReady is low here, so no accept can coincide.
            m_payload_r <= s_payload_r;
            s_full_r    <= 1'b0;
            m_valid_r   <= 1'b1;
        end else if (drain_s || !m_valid_r) begin
            m_valid_r <= accept_s;
            if (accept_s) begin
                m_payload_r <= new_payload_s;
            end else begin
                m_payload_r <= m_payload_r;
            end
        end else if (accept_s) begin
            s_payload_r <= new_payload_s;
            s_full_r    <= 1'b1;
        end else begin
            s_full_r <= s_full_r;
        end
    end

    assign OutValid = m_valid_r;
    assign DataOut  = m_payload_r[PW-1:3];
    assign CarryOut = m_payload_r[2];
    assign ZeroOut  = m_payload_r[1];
    assign ModeErr  = m_payload_r[0];

endmodule

// File: tb/tb_operand_conditioner.sv
// -----------------------------------------------------------------------------
// tb_operand_conditioner
// Self-checking bench: vector table, hand-written backpressure/reset sequences,
// back-to-back streaming, a 16-bit instance, and a random handshake run
// scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_operand_conditioner;
    import alu_cond_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       carry_out, zero_out, mode_err;
    logic [7:0] data_bus, data_out;
    logic [2:0] mode;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic        carry16, zero16, err16;
    logic [15:0] data_bus16, data_out16;
    logic [2:0]  mode16;

    int n_checks = 0;
    int n_fail   = 0;

    operand_conditioner #(.WIDTH(8)) dut (
        .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(in_ready),
        .DataBus(data_bus), .Mode(mode), .OutValid(out_valid), .OutReady(out_ready),
        .DataOut(data_out), .CarryOut(carry_out), .ZeroOut(zero_out), .ModeErr(mode_err)
    );

    operand_conditioner #(.WIDTH(16)) dut16 (
        .Clk(clk), .Rst_n(rst_n), .InValid(in_valid16), .InReady(in_ready16),
        .DataBus(data_bus16), .Mode(mode16), .OutValid(out_valid16), .OutReady(out_ready16),
        .DataOut(data_out16), .CarryOut(carry16), .ZeroOut(zero16), .ModeErr(err16)
    );

    typedef struct {
        logic [2:0] m;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic       exp_c;
        logic       exp_z;
        logic       exp_e;
    } vec_t;

    typedef struct {
        longint r;
        bit     c;
        bit     z;
        bit     e;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference model of the transform for a w-bit operand.
    function automatic exp_t ref_op(input int w, input longint d, input int m);
        exp_t   x;
        longint md = longint'(1) << w;
        x.c = 1'b0;
        x.e = 1'b0;
        case (m)
            0: x.r = d;
            1: x.r = md - 1 - d;
            2: begin
                x.r = (md - d) % md;
                x.c = (d == 0);
            end
            3: begin
                x.r = 0;
                for (int k = 0; k < w / 4; k++) begin
                    longint n = (d >> (4 * k)) & 15;
                    x.r = x.r + (((9 - n + 16) % 16) << (4 * k));
                end
            end
            4: x.r = 0;
            5: x.r = md - 1;
            default: begin
                x.r = d;
                x.e = 1'b1;
            end
        endcase
        x.z = (x.r == 0);
        return x;
    endfunction

    task automatic drive8(input logic v, input logic [2:0] m, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        mode     = m;
        data_bus = d;
    endtask

    task automatic chk_out8(input string name, input exp_t x);
        chk({name, ".valid"}, out_valid, 1);
        chk({name, ".data"},  data_out, x.r);
        chk({name, ".carry"}, carry_out, x.c);
        chk({name, ".zero"},  zero_out, x.z);
        chk({name, ".err"},   mode_err, x.e);
    endtask

    initial begin
        exp_t x;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; data_bus = 8'h00; mode = 3'd0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; data_bus16 = 16'h0000; mode16 = 3'd0;

        vecs[0]  = '{3'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd1, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd2, 8'h3C, 8'hC4, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 8'h3C, 8'h6D, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd5, 8'h3C, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd7, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{3'd6, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{3'd2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{3'd2, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'd2, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0};

        // Reset values
        #12;
        chk("rst.valid", out_valid, 0);
        chk("rst.data", data_out, 8'h00);
        chk("rst.carry", carry_out, 0);
        chk("rst.zero", zero_out, 1);
        chk("rst.err", mode_err, 0);
        chk("rst.inready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, one operand per transfer with OutReady high
        for (int i = 0; i < 12; i++) begin
            drive8(1'b1, vecs[i].m, vecs[i].d);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.valid", i), out_valid, 1);
            chk($sformatf("vec%0d.data", i), data_out, vecs[i].exp_d);
            chk($sformatf("vec%0d.carry", i), carry_out, vecs[i].exp_c);
            chk($sformatf("vec%0d.zero", i), zero_out, vecs[i].exp_z);
            chk($sformatf("vec%0d.err", i), mode_err, vecs[i].exp_e);
        end
        drive8(1'b0, 3'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("idle.valid", out_valid, 0);

        // Backpressure: 11 and 22 fill M and S, 33 is held off
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; mode = 3'd0; data_bus = 8'h11;
        @(posedge clk);
        #1;
        chk("bp.ready1", in_ready, 1);
        drive8(1'b1, 3'd0, 8'h22);
        @(posedge clk);
        #1;
        chk("bp.ready2", in_ready, 0);
        chk("bp.hold1", data_out, 8'h11);
        drive8(1'b1, 3'd0, 8'h33);
        @(posedge clk);
        #1;
        chk("bp.blocked.ready", in_ready, 0);
        chk("bp.blocked.valid", out_valid, 1);
        chk("bp.blocked.data", data_out, 8'h11);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.out22.valid", out_valid, 1);
        chk("bp.out22", data_out, 8'h22);
        chk("bp.ready3", in_ready, 1);
        @(posedge clk);
        #1;
        chk("bp.out33.valid", out_valid, 1);
        chk("bp.out33", data_out, 8'h33);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp.empty", out_valid, 0);

        // Back-to-back streaming: zero bubbles, InReady stays high
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic [2:0] m;
            d = 8'($urandom);
            m = 3'($urandom_range(0, 7));
            drive8(1'b1, m, d);
            chk($sformatf("stream%0d.inready", i), in_ready, 1);
            @(posedge clk);
            #1;
            chk_out8($sformatf("stream%0d", i), ref_op(8, longint'(d), int'(m)));
        end
        drive8(1'b0, 3'd0, 8'h00);
        @(posedge clk);
        #1;
        chk("stream.drained", out_valid, 0);

        // 16-bit instance: fixed NINES case, then random operands
        @(negedge clk);
        in_valid16 = 1'b1; mode16 = 3'd3; data_bus16 = 16'h09AF;
        @(posedge clk);
        #1;
        chk("w16.nines.valid", out_valid16, 1);
        chk("w16.nines", data_out16, 16'h90FA);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d;
            logic [2:0]  m;
            d = 16'($urandom);
            m = 3'($urandom_range(0, 7));
            @(negedge clk);
            mode16 = m; data_bus16 = d;
            @(posedge clk);
            #1;
            x = ref_op(16, longint'(d), int'(m));
            chk($sformatf("w16r%0d.data", i), data_out16, x.r);
            chk($sformatf("w16r%0d.carry", i), carry16, x.c);
            chk($sformatf("w16r%0d.zero", i), zero16, x.z);
            chk($sformatf("w16r%0d.err", i), err16, x.e);
        end
        @(negedge clk);
        in_valid16 = 1'b0;

        // Random handshake against a FIFO scoreboard of depth two
        sb.delete();
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            logic [2:0] m;
            @(negedge clk);
            d = 8'($urandom);
            m = 3'($urandom_range(0, 7));
            in_valid  = (i < 294) ? 1'($urandom) : 1'b0;
            out_ready = (i < 294) ? ($urandom_range(0, 3) != 0) : 1'b1;
            mode = m; data_bus = d;
            chk($sformatf("rnd%0d.valid", i), out_valid, (sb.size() > 0));
            chk($sformatf("rnd%0d.inready", i), in_ready, (sb.size() < 2));
            if (out_valid && out_ready && sb.size() > 0) begin
                chk_out8($sformatf("rnd%0d", i), sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_op(8, longint'(d), int'(m)));
            end
        end
        chk("rnd.sb_empty", sb.size(), 0);

        // Mid-stream reset with M and S both full
        drive8(1'b1, 3'd5, 8'h5A);
        out_ready = 1'b0;
        @(posedge clk);
        drive8(1'b1, 3'd1, 8'hA5);
        @(posedge clk);
        #1;
        chk("mrst.pre.inready", in_ready, 0);
        chk("mrst.pre.valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", out_valid, 0);
        chk("mrst.data", data_out, 8'h00);
        chk("mrst.zero", zero_out, 1);
        chk("mrst.carry", carry_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mrst.inready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("mrst.after.valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
